// File: rtl/attack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attack_pkg
// Description : Shared definitions for the attack overlay: per-channel state
//               encoding, the blanking colour and default rectangle geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package attack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } attack_state_t;

    localparam logic [11:0] BLACK          = 12'h000;
    localparam logic [11:0] DEFAULT_COLOR  = 12'hfff;
    localparam int          DEFAULT_WIDTH  = 40;
    localparam int          DEFAULT_HEIGHT = 20;

endpackage
`default_nettype wire

// File: rtl/attack_channel.sv
`default_nettype none
// ============================================================================
// Module      : attack_channel
// Description : One attack channel. It accepts a fire request in IDLE and
//               latches position and orientation. It counts frame ticks
//               through ACTIVE and COOLDOWN. It also registers the stage-1 hit
//               flag for the current pixel.
// Ports       : clk, rst_n           - pixel clock, async active-low reset
//               tick                 - one-cycle frame tick
//               fire_req             - fire request (level)
//               x_pos, y_pos         - live position, latched on accept
//               direction            - 1 = WIDTHxHEIGHT, 0 = HEIGHTxWIDTH
//               hcount, vcount       - current pixel counters
//               fire_ack             - one-cycle accept pulse
//               active, ready        - state in ACTIVE / IDLE
//               hit                  - registered hit for the pixel
// Revision    : 1.0 - initial release
// ============================================================================
module attack_channel
    import attack_pkg::*;
#(
    parameter int COORD_W         = 12,
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int HEIGHT          = DEFAULT_HEIGHT,
    parameter int LIFE_FRAMES     = 30,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               fire_req,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               direction,
    input  logic [10:0]        hcount,
    input  logic [10:0]        vcount,
    output logic               fire_ack,
    output logic               active,
    output logic               ready,
    output logic               hit
);

    localparam int c_max_frames = (LIFE_FRAMES > COOLDOWN_FRAMES) ? LIFE_FRAMES : COOLDOWN_FRAMES;
    localparam int c_cnt_w      = $clog2(c_max_frames + 1);
    localparam int c_ext_w      = COORD_W + 1;

    localparam logic [c_cnt_w-1:0] c_life   = c_cnt_w'(LIFE_FRAMES);
    localparam logic [c_cnt_w-1:0] c_cool   = c_cnt_w'(COOLDOWN_FRAMES);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic [c_ext_w-1:0] c_width  = c_ext_w'(WIDTH);
    localparam logic [c_ext_w-1:0] c_height = c_ext_w'(HEIGHT);

    attack_state_t        r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [COORD_W-1:0]   r_x, r_y;
    logic                 r_dir;
    logic                 w_latch, w_ack_nxt, w_hit;

    // The one-bit guard keeps x+W from wrapping near the top of the
    // coordinate range.
    logic [c_ext_w-1:0]   w_x, w_y, w_h, w_v, w_w_eff, w_h_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dir    <= 1'b0;
            fire_ack <= 1'b0;
            hit      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            fire_ack <= w_ack_nxt;
            hit      <= w_hit;
            if (w_latch) begin
                r_x   <= x_pos;
                r_y   <= y_pos;
                r_dir <= direction;
            end
        end
    end

    // IDLE does not look at tick. A tick in the accepting cycle is not
    // counted as a result.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fire_req) begin
                    w_latch     = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = c_life;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    if (r_cnt == c_one) begin
                        if (COOLDOWN_FRAMES == 0) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_COOLDOWN;
                            w_cnt_nxt   = c_cool;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - c_one;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (r_cnt == c_one) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_one;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_x     = c_ext_w'(r_x);
    assign w_y     = c_ext_w'(r_y);
    assign w_h     = c_ext_w'(hcount);
    assign w_v     = c_ext_w'(vcount);
    assign w_w_eff = r_dir ? c_width  : c_height;
    assign w_h_eff = r_dir ? c_height : c_width;

    assign w_hit = (r_state == ST_ACTIVE)
                && (w_h >= w_x) && (w_h < w_x + w_w_eff)
                && (w_v >= w_y) && (w_v < w_y + w_h_eff);

    assign active = (r_state == ST_ACTIVE);
    assign ready  = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/draw_attack_multi.sv
`default_nettype none
// ============================================================================
// Module      : draw_attack_multi
// Description : Multi-channel attack overlay. Each channel draws a fixed-colour
//               rectangle for LIFE_FRAMES frames after a fire and then cools
//               down. The pixel path and the timing signals have a matched
//               latency of two cycles.
// Ports       : clk, rst_n                     - pixel clock, async reset (low)
//               vcount_in, hcount_in          - pixel counters
//               vsync_in, vblnk_in,
//               hsync_in, hblnk_in            - timing
//               rgb_in                        - upstream pixel
//               fire_req, x_pos, y_pos,
//               direction                     - per-channel fire controls
//               fire_ack, active, ready       - per-channel status
//               *_out                         - delayed timing and pixel
// Revision    : 1.0 - initial release
// ============================================================================
module draw_attack_multi
    import attack_pkg::*;
#(
    parameter int          N_CH            = 2,
    parameter int          COORD_W         = 12,
    parameter int          WIDTH           = DEFAULT_WIDTH,
    parameter int          HEIGHT          = DEFAULT_HEIGHT,
    parameter logic [11:0] COLOR           = DEFAULT_COLOR,
    parameter int          LIFE_FRAMES     = 30,
    parameter int          COOLDOWN_FRAMES = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [10:0]               vcount_in,
    input  logic [10:0]               hcount_in,
    input  logic                      vsync_in,
    input  logic                      vblnk_in,
    input  logic                      hsync_in,
    input  logic                      hblnk_in,
    input  logic [11:0]               rgb_in,
    input  logic [N_CH-1:0]           fire_req,
    input  logic [N_CH*COORD_W-1:0]   x_pos,
    input  logic [N_CH*COORD_W-1:0]   y_pos,
    input  logic [N_CH-1:0]           direction,
    output logic [N_CH-1:0]           fire_ack,
    output logic [N_CH-1:0]           active,
    output logic [N_CH-1:0]           ready,
    output logic [10:0]               vcount_out,
    output logic [10:0]               hcount_out,
    output logic                      vsync_out,
    output logic                      vblnk_out,
    output logic                      hsync_out,
    output logic                      hblnk_out,
    output logic [11:0]               rgb_out
);

    logic [10:0] r1_vcount, r1_hcount;
    logic        r1_vsync, r1_vblnk, r1_hsync, r1_hblnk;
    logic [11:0] r1_rgb;
    logic [N_CH-1:0] w_hit;
    logic        w_tick;
    logic [11:0] w_pix;

    // The stage-1 vsync register is the registered copy used for edge
    // detection.
    assign w_tick = vsync_in & ~r1_vsync;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            attack_channel #(
                .COORD_W         (COORD_W),
                .WIDTH           (WIDTH),
                .HEIGHT          (HEIGHT),
                .LIFE_FRAMES     (LIFE_FRAMES),
                .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (w_tick),
                .fire_req  (fire_req[gi]),
                .x_pos     (x_pos[gi*COORD_W +: COORD_W]),
                .y_pos     (y_pos[gi*COORD_W +: COORD_W]),
                .direction (direction[gi]),
                .hcount    (hcount_in),
                .vcount    (vcount_in),
                .fire_ack  (fire_ack[gi]),
                .active    (active[gi]),
                .ready     (ready[gi]),
                .hit       (w_hit[gi])
            );
        end
    endgenerate

    // Stage 1: timing and pixel, aligned with the registered hit vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vcount <= '0;
            r1_hcount <= '0;
            r1_vsync  <= 1'b0;
            r1_vblnk  <= 1'b0;
            r1_hsync  <= 1'b0;
            r1_hblnk  <= 1'b0;
            r1_rgb    <= '0;
        end else begin
            r1_vcount <= vcount_in;
            r1_hcount <= hcount_in;
            r1_vsync  <= vsync_in;
            r1_vblnk  <= vblnk_in;
            r1_hsync  <= hsync_in;
            r1_hblnk  <= hblnk_in;
            r1_rgb    <= rgb_in;
        end
    end

    assign w_pix = (r1_vblnk | r1_hblnk) ? BLACK :
                   (|w_hit)             ? COLOR : r1_rgb;

    // Stage 2: final outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_out <= r1_vcount;
            hcount_out <= r1_hcount;
            vsync_out  <= r1_vsync;
            vblnk_out  <= r1_vblnk;
            hsync_out  <= r1_hsync;
            hblnk_out  <= r1_hblnk;
            rgb_out    <= w_pix;
        end
    end

endmodule
`default_nettype wire
